// File: rtl/clock_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : clock_reset_seq
//  Description : Generates a divided clock (clk_out) with a programmable
//                half-period and NUM_CH reset outputs. After a start request
//                the channels are released one after another, following a
//                programmable hold. An optional bounded run follows, and the
//                sequence ends on a count or a stop request.
//                Optional feature macro: CLOCK_RESET_SEQ_CH_CLK_EN adds the
//                per-channel gated clock output clk_ch.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_reset_seq #(
  parameter int   NUM_CH       = 4,
  parameter int   CNT_W        = 16,
  parameter int   STAGGER      = 1,
  parameter logic ACTIVE_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  reset_hold,
  input  logic [CNT_W-1:0]  half_period,
  input  logic [CNT_W-1:0]  count,
  output logic              clk_out,
  output logic              tick,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done
`ifdef CLOCK_RESET_SEQ_CH_CLK_EN
  ,
  output logic [NUM_CH-1:0] clk_ch
`endif
);

  // Release thresholds carry 4 extra bits so reset_hold + k*STAGGER never wraps.
  localparam int c_rw = CNT_W + 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_hold;
  logic [CNT_W-1:0]  r_hp;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_div_cnt;
  logic [CNT_W-1:0]  r_tcnt;
  logic [c_rw-1:0]   r_pcnt;

  logic [c_rw-1:0]   w_rel_at  [NUM_CH];   // thresholds from latched config
  logic [c_rw-1:0]   w_rel_new [NUM_CH];   // thresholds from incoming config
  logic [CNT_W-1:0]  w_hp_m1;
  logic              w_busy_st;
  logic              w_start_ok;
  logic              w_toggle_pt;
  logic              w_stop_hit;
  logic              w_do_toggle;
  logic [c_rw-1:0]   w_pcnt_nxt;
  logic [NUM_CH-1:0] w_released;
  logic [NUM_CH-1:0] w_rel_nxt;
  logic              w_clk_nxt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_rel
    assign w_rel_at[k]  = {4'd0, r_hold}     + c_rw'(k * STAGGER);
    assign w_rel_new[k] = {4'd0, reset_hold} + c_rw'(k * STAGGER);
  end

  // A half_period of 0 behaves exactly like 1.
  assign w_hp_m1     = (r_hp == '0) ? '0 : r_hp - 1'b1;
  assign w_busy_st   = (r_state == S_HOLD) || (r_state == S_RUN);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_toggle_pt = w_busy_st && (r_div_cnt == w_hp_m1);
  // stop only acts in RUN; the release sequence in HOLD always completes.
  assign w_stop_hit  = (r_state == S_RUN) && stop && w_toggle_pt;
  assign w_do_toggle = w_toggle_pt && !w_stop_hit;
  assign w_pcnt_nxt  = r_pcnt + 1'b1;
  assign w_released  = rst_out ^ {NUM_CH{ACTIVE_RESET}};

  // Next clk_out level and next per-channel release state, shared by the
  // FSM and the optional gated clocks so both see the same edge.
  always_comb begin
    w_clk_nxt = clk_out;
    w_rel_nxt = w_released;
    if (reset) begin
      w_clk_nxt = 1'b0;
      w_rel_nxt = '0;
    end else if (w_start_ok) begin
      w_clk_nxt = 1'b0;
      // Channels with a zero threshold release on the sequence-entry edge.
      for (int k = 0; k < NUM_CH; k++) begin
        w_rel_nxt[k] = (w_rel_new[k] == '0);
      end
    end else if (w_do_toggle) begin
      w_clk_nxt = ~clk_out;
      // Full periods are counted on falling toggles; release happens on the
      // edge where the period count reaches each channel's threshold.
      if ((r_state == S_HOLD) && clk_out) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (w_pcnt_nxt == w_rel_at[k]) begin
            w_rel_nxt[k] = 1'b1;
          end
        end
      end
    end
  end

  // Sequencer FSM: config latch, divider, period/toggle counters, outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_hp      <= '0;
      r_count   <= '0;
      r_div_cnt <= '0;
      r_tcnt    <= '0;
      r_pcnt    <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      rst_out   <= {NUM_CH{ACTIVE_RESET}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      tick    <= 1'b0;
      clk_out <= w_clk_nxt;
      rst_out <= w_rel_nxt ^ {NUM_CH{ACTIVE_RESET}};
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_hold    <= reset_hold;
            r_hp      <= half_period;
            r_count   <= count;
            r_div_cnt <= '0;
            r_pcnt    <= '0;
            r_tcnt    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            // When even the last channel has a zero threshold, every channel
            // releases on entry and the run starts immediately.
            r_state   <= (w_rel_new[NUM_CH-1] == '0) ? S_RUN : S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_toggle_pt) begin
            r_div_cnt <= '0;
            tick      <= 1'b1;
            if (clk_out) begin
              r_pcnt <= w_pcnt_nxt;
            end
            if (w_rel_nxt[NUM_CH-1]) begin
              r_state <= S_RUN;
              r_tcnt  <= '0;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (w_toggle_pt) begin
            r_div_cnt <= '0;
            if (stop) begin
              // Stop wins over everything at a toggle point: no toggle.
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              tick   <= 1'b1;
              r_tcnt <= r_tcnt + 1'b1;
              if ((r_count != '0) && ((r_tcnt + 1'b1) == r_count)) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CLOCK_RESET_SEQ_CH_CLK_EN
  // Per-channel gated clocks: follow the next clk_out once a channel is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ch <= '0;
    end else begin
      clk_ch <= w_rel_nxt & {NUM_CH{w_clk_nxt}};
    end
  end
`endif

endmodule
`default_nettype wire
